// File: rtl/mem_core_arbiter_pkg.sv
// mem_arb_pkg: shared types for the memory core arbiter.
// Holds FSM/owner enums and the legal LATENCY range.
`ifndef LINE_WIDTH
`define LINE_WIDTH 32
`endif

package mem_arb_pkg;
    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        ACCESS,
        RESP
    } state_t;

    typedef enum logic {
        OWN_IC,
        OWN_DC
    } owner_t;

    localparam int LAT_MIN = 1;
    localparam int LAT_MAX = 15;
    localparam int CNT_W   = 4;
endpackage

// File: rtl/mem_core_arbiter_rr_arbiter2.sv
// rr_arbiter2: 2-way round-robin grant (bit0=IC, bit1=DC).
// Ports: clock, reset (async active-low), req[1:0], advance, grant[1:0].
module rr_arbiter2
    import mem_arb_pkg::*;
(
    input  logic       clock,
    input  logic       reset,
    input  logic [1:0] req,
    input  logic       advance,
    output logic [1:0] grant
);

    owner_t prio;

    // Contention is settled by prio; a lone requester always wins.
    always_comb begin
        grant = req;
        if (req == 2'b11) begin
            grant = (prio == OWN_DC) ? 2'b10 : 2'b01;
        end
    end

    // After a grant the pointer moves to the port that lost.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            prio <= OWN_DC;
        end else if (advance) begin
            prio <= grant[1] ? OWN_IC : OWN_DC;
        end
    end

endmodule

// File: rtl/mem_core_arbiter.sv
// mem_core_arbiter: shares the line-wide memory core between IC and DC.
// Ports: ic/dc valid-ready requests, one-cycle rsp pulses, mem_* core bundle.
module mem_core_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = `LINE_WIDTH,
    parameter int LATENCY    = 2
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  ic_req_valid,
    output logic                  ic_req_ready,
    input  logic [ADDR_WIDTH-1:0] ic_req_addr,
    output logic                  ic_rsp_valid,
    output logic [DATA_WIDTH-1:0] ic_rsp_data,
    input  logic                  dc_req_valid,
    output logic                  dc_req_ready,
    input  logic                  dc_req_write,
    input  logic [ADDR_WIDTH-1:0] dc_req_addr,
    input  logic [DATA_WIDTH-1:0] dc_req_data,
    output logic                  dc_rsp_valid,
    output logic [DATA_WIDTH-1:0] dc_rsp_data,
    output logic                  mem_read,
    output logic                  mem_write,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic [DATA_WIDTH-1:0] mem_rdata
);

    // Out-of-range LATENCY is clamped into the legal window.
    localparam int LAT = (LATENCY < LAT_MIN) ? LAT_MIN :
                         (LATENCY > LAT_MAX) ? LAT_MAX : LATENCY;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LAT - 1);

    state_t                state;
    state_t                state_nx;
    logic [CNT_W-1:0]      cnt;
    owner_t                owner;
    logic                  write_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic [1:0]            grant;
    logic                  accept;

    rr_arbiter2 u_rr (
        .clock   (clock),
        .reset   (reset),
        .req     ({dc_req_valid, ic_req_valid}),
        .advance (accept),
        .grant   (grant)
    );

    assign ic_req_ready = (state == IDLE) & grant[0];
    assign dc_req_ready = (state == IDLE) & grant[1];
    assign accept       = ic_req_ready | dc_req_ready;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx     = state;
        mem_read     = 1'b0;
        mem_write    = 1'b0;
        ic_rsp_valid = 1'b0;
        dc_rsp_valid = 1'b0;
        unique case (state)
            IDLE: begin
                if (accept) state_nx = WAIT;
            end
            WAIT: begin
                if (cnt == '0) state_nx = ACCESS;
            end
            ACCESS: begin
                mem_read  = ~write_q;
                mem_write = write_q;
                state_nx  = RESP;
            end
            RESP: begin
                ic_rsp_valid = (owner == OWN_IC);
                dc_rsp_valid = (owner == OWN_DC);
                state_nx     = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    // Latched request; mem_addr/mem_wdata hold it between accesses.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            owner   <= OWN_IC;
            write_q <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            cnt     <= '0;
        end else if (accept) begin
            owner   <= dc_req_ready ? OWN_DC : OWN_IC;
            write_q <= dc_req_ready & dc_req_write;
            addr_q  <= dc_req_ready ? dc_req_addr : ic_req_addr;
            if (dc_req_ready) wdata_q <= dc_req_data;
            cnt     <= CNT_LOAD;
        end else if (state == WAIT && cnt != '0) begin
            cnt <= cnt - 1'b1;
        end
    end

    // Only the owner's response register is touched, and only on reads.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            ic_rsp_data <= '0;
            dc_rsp_data <= '0;
        end else if (state == ACCESS && !write_q) begin
            if (owner == OWN_IC) ic_rsp_data <= mem_rdata;
            else                 dc_rsp_data <= mem_rdata;
        end
    end

    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;

endmodule
